// File: rtl/io_output_arbiter_rr.sv
// rtl/io_output_arbiter_rr.sv - round-robin print arbiter feeding a core-tagged output FIFO
module io_output_arbiter_rr #(
  parameter  int NUM_CORES  = 2,
  parameter  int DATA_WIDTH = 32,
  parameter  int FIFO_DEPTH = 4,
  localparam int ID_W       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_CORES-1:0]            req_i,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] data_i,
  output logic [NUM_CORES-1:0]            done_o,
  output logic                            print_valid_o,
  output logic [DATA_WIDTH-1:0]           print_data_o,
  output logic [ID_W-1:0]                 print_id_o,
  input  logic                            print_ready_i,
  output logic [LVL_W-1:0]                fifo_level_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = ID_W + DATA_WIDTH;

  logic [ID_W-1:0]        rr_ptr;
  logic [NUM_CORES-1:0]   eligible;
  logic [2*NUM_CORES-1:0] eligible_dbl;
  logic [NUM_CORES-1:0]   eligible_rot;
  logic                   grant_valid;
  logic [ID_W-1:0]        grant_idx;
  logic [DATA_WIDTH-1:0]  grant_data;
  logic [NUM_CORES-1:0]   done_next;
  int                     idx_sum;

  logic [ENT_W-1:0]       mem [FIFO_DEPTH];
  logic [ENT_W-1:0]       head;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [LVL_W-1:0]       level;
  logic                   push;
  logic                   pop;

  // Rotating a doubled copy puts core ptr+1 at bit 0, so the lowest set bit wins.
  always_comb begin
    eligible     = req_i & ~done_o;
    eligible_dbl = {eligible, eligible} >> (int'(rr_ptr) + 1);
    eligible_rot = eligible_dbl[NUM_CORES-1:0];
    grant_valid  = 1'b0;
    grant_idx    = '0;
    idx_sum      = 0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!grant_valid && eligible_rot[i]) begin
        grant_valid = 1'b1;
        idx_sum     = int'(rr_ptr) + 1 + i;
        if (idx_sum >= NUM_CORES) idx_sum = idx_sum - NUM_CORES;
        grant_idx   = idx_sum[ID_W-1:0];
      end
    end
  end

  assign push = grant_valid && (level < LVL_W'(FIFO_DEPTH));
  assign pop  = (level != '0) && print_ready_i;

  always_comb begin
    grant_data = '0;
    done_next  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (grant_idx == ID_W'(i)) begin
        grant_data   = data_i[i*DATA_WIDTH +: DATA_WIDTH];
        done_next[i] = push;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= ID_W'(NUM_CORES - 1);
      done_o <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      done_o <= done_next;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= grant_idx;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the level is zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {grant_idx, grant_data};
  end

  assign head          = mem[rd_ptr];
  assign print_valid_o = (level != '0);
  assign print_data_o  = print_valid_o ? head[DATA_WIDTH-1:0] : '0;
  assign print_id_o    = print_valid_o ? head[ENT_W-1 -: ID_W] : '0;
  assign fifo_level_o  = level;

endmodule

// File: tb/tb_io_output_arbiter_rr.sv
// tb/tb_io_output_arbiter_rr.sv - self-checking bench for io_output_arbiter_rr
module tb_io_output_arbiter_rr;
  localparam int N     = 2;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int IDW   = 1;
  localparam int LW    = 3;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N-1:0]         req = '0;
  logic [N-1:0][DW-1:0] dat = '0;
  logic                 ready = 1'b0;
  logic [N-1:0]         done;
  logic                 valid;
  logic [DW-1:0]        pdata;
  logic [IDW-1:0]       pid;
  logic [LW-1:0]        level;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [IDW-1:0] id;
    logic [DW-1:0]  d;
  } ent_t;

  ent_t         m_q[$];
  int           m_ptr;
  logic [N-1:0] m_done;

  io_output_arbiter_rr #(.NUM_CORES(N), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .data_i(dat), .done_o(done),
    .print_valid_o(valid), .print_data_o(pdata), .print_id_o(pid),
    .print_ready_i(ready), .fifo_level_o(level)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    m_q.delete();
    m_ptr  = N - 1;
    m_done = '0;
  endtask

  // Queue-based reference: pop head if ready, grant first eligible core after m_ptr if room.
  task automatic model_edge();
    int           g;
    bit           room;
    bit           do_pop;
    ent_t         e;
    logic [N-1:0] nd;
    g      = -1;
    nd     = '0;
    room   = (m_q.size() < DEPTH);
    do_pop = (m_q.size() != 0) && ready;
    for (int s = 1; s <= N; s++) begin
      int k;
      k = (m_ptr + s) % N;
      if (g < 0 && req[k] && !m_done[k]) g = k;
    end
    if (do_pop) void'(m_q.pop_front());
    if (g >= 0 && room) begin
      e.id = IDW'(g);
      e.d  = dat[g];
      m_q.push_back(e);
      m_ptr = g;
      nd[g] = 1'b1;
    end
    m_done = nd;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    ready = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '0;
    ready = 1'b0;
    #1;
    tests++; if (done !== '0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid); end
    tests++; if (pdata !== '0) begin fails++; $display("FAIL reset_data: got %h want 0", pdata); end
    tests++; if (pid !== '0) begin fails++; $display("FAIL reset_id: got %h want 0", pid); end
    tests++; if (level !== '0) begin fails++; $display("FAIL reset_level: got %0d want 0", level); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    req    = 2'b01;
    dat[0] = 32'hDEAD_BEEF;
    ready  = 1'b1;
    tick();
    tests++; if (done !== 2'b01) begin fails++; $display("FAIL single_done: got %b want 01", done); end
    tests++; if (valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", valid); end
    tests++; if (pdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL single_data: got %h want deadbeef", pdata); end
    tests++; if (pid !== '0) begin fails++; $display("FAIL single_id: got %h want 0", pid); end
    tick();
    req = '0;
    tests++; if (done !== '0) begin fails++; $display("FAIL single_nodouble: got %b want 00", done); end
    tests++; if (level !== '0) begin fails++; $display("FAIL single_level: got %0d want 0", level); end
  endtask

  task automatic test_fairness();
    int           exp;
    logic [DW-1:0] word;
    logic [N-1:0] wd;
    do_reset();
    for (int k = 0; k < N; k++) dat[k] = $urandom;
    req   = '1;
    ready = 1'b1;
    exp   = 0;
    for (int c = 0; c < 8; c++) begin
      word = dat[exp];
      tick();
      wd = '0;
      wd[exp] = 1'b1;
      tests++; if (done !== wd) begin fails++; $display("FAIL fair_done c%0d: got %b want %b", c, done, wd); end
      tests++; if (pdata !== word || pid !== IDW'(exp)) begin fails++; $display("FAIL fair_head c%0d: got %h/%0d want %h/%0d", c, pdata, pid, word, exp); end
      tests++; if (level !== LW'(1)) begin fails++; $display("FAIL fair_level c%0d: got %0d want 1", c, level); end
      dat[exp] = $urandom;
      exp = (exp + 1) % N;
    end
    req = '0;
    tick();
    tests++; if (level !== '0) begin fails++; $display("FAIL fair_drain: got %0d want 0", level); end
  endtask

  task automatic test_full();
    logic [DW-1:0] d [5];
    for (int i = 0; i < 5; i++) d[i] = $urandom;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req[1] = 1'b1;
      dat[1] = d[i];
      tick();
      tests++; if (done !== 2'b10 || level !== LW'(i + 1)) begin fails++; $display("FAIL full_accept %0d: got %b/%0d want 10/%0d", i, done, level, i + 1); end
      tick();
      tests++; if (done !== '0 || level !== LW'(i + 1)) begin fails++; $display("FAIL full_mask %0d: got %b/%0d want 00/%0d", i, done, level, i + 1); end
    end
    dat[1] = d[4];
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (done !== '0 || level !== LW'(4) || pdata !== d[0]) begin fails++; $display("FAIL full_stall %0d: got %b/%0d/%h want 00/4/%h", i, done, level, pdata, d[0]); end
    end
    ready = 1'b1;
    tick();
    tests++; if (done !== '0 || level !== LW'(3) || pdata !== d[1]) begin fails++; $display("FAIL full_popblock: got %b/%0d/%h want 00/3/%h", done, level, pdata, d[1]); end
    ready = 1'b0;
    tick();
    tests++; if (done !== 2'b10 || level !== LW'(4)) begin fails++; $display("FAIL full_fifth: got %b/%0d want 10/4", done, level); end
    ready = 1'b1;
    tick();
    req[1] = 1'b0;
    tests++; if (level !== LW'(3) || pdata !== d[2]) begin fails++; $display("FAIL full_pop: got %0d/%h want 3/%h", level, pdata, d[2]); end
    for (int j = 2; j < 5; j++) begin
      tests++; if (pdata !== d[j] || pid !== 1'b1) begin fails++; $display("FAIL full_order %0d: got %h/%0d want %h/1", j, pdata, pid, d[j]); end
      tick();
    end
    tests++; if (level !== '0 || valid !== 1'b0) begin fails++; $display("FAIL full_empty: got %0d/%b want 0/0", level, valid); end
  endtask

  task automatic test_wrap();
    ent_t acc[$];
    ent_t w;
    int   exp;
    bit   rdy;
    logic [N-1:0] wd;
    do_reset();
    for (int k = 0; k < N; k++) dat[k] = $urandom;
    req = '1;
    exp = 0;
    for (int p = 0; p < 6; p++) begin
      w.id  = IDW'(exp);
      w.d   = dat[exp];
      rdy   = (p >= 2);
      ready = rdy;
      if (rdy) begin
        tests++; if (pdata !== acc[0].d || pid !== acc[0].id) begin fails++; $display("FAIL wrap_head %0d: got %h/%0d want %h/%0d", p, pdata, pid, acc[0].d, acc[0].id); end
      end
      tick();
      if (rdy) void'(acc.pop_front());
      acc.push_back(w);
      wd = '0;
      wd[exp] = 1'b1;
      tests++; if (done !== wd) begin fails++; $display("FAIL wrap_done %0d: got %b want %b", p, done, wd); end
      tests++; if (level !== LW'((p < 2) ? p + 1 : 2)) begin fails++; $display("FAIL wrap_level %0d: got %0d want %0d", p, level, (p < 2) ? p + 1 : 2); end
      dat[exp] = $urandom;
      exp = (exp + 1) % N;
    end
    req   = '0;
    ready = 1'b1;
    while (acc.size() > 0) begin
      tests++; if (pdata !== acc[0].d || pid !== acc[0].id) begin fails++; $display("FAIL wrap_drain: got %h/%0d want %h/%0d", pdata, pid, acc[0].d, acc[0].id); end
      tick();
      void'(acc.pop_front());
    end
    tests++; if (level !== '0) begin fails++; $display("FAIL wrap_empty: got %0d want 0", level); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] a;
    do_reset();
    for (int k = 0; k < N; k++) dat[k] = $urandom;
    req = '1;
    repeat (3) tick();
    tests++; if (level !== LW'(3)) begin fails++; $display("FAIL mid_fill: got %0d want 3", level); end
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    tests++; if (done !== '0 || valid !== 1'b0 || level !== '0) begin fails++; $display("FAIL mid_clear: got %b/%b/%0d want 00/0/0", done, valid, level); end
    tests++; if (pdata !== '0 || pid !== '0) begin fails++; $display("FAIL mid_head: got %h/%0d want 0/0", pdata, pid); end
    a      = $urandom;
    dat[0] = a;
    dat[1] = ~a;
    #2 rst_n = 1'b1;
    tick();
    tests++; if (done !== 2'b01 || pid !== '0 || pdata !== a || level !== LW'(1)) begin fails++; $display("FAIL mid_first: got %b/%0d/%h/%0d want 01/0/%h/1", done, pid, pdata, level, a); end
  endtask

  task automatic test_empty_ready();
    do_reset();
    ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      tests++; if (valid !== 1'b0 || level !== '0) begin fails++; $display("FAIL empty_ready %0d: got %b/%0d want 0/0", c, valid, level); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0] dprev;
      dprev = m_done;
      ready = ($urandom_range(0, 99) < (((c % 200) < 100) ? 25 : 85));
      tick();
      tests++; if (done !== m_done) begin fails++; $display("FAIL rand_done c%0d: got %b want %b", c, done, m_done); end
      tests++; if (level !== LW'(m_q.size()) || valid !== (m_q.size() != 0)) begin fails++; $display("FAIL rand_level c%0d: got %0d/%b want %0d", c, level, valid, m_q.size()); end
      if (m_q.size() != 0) begin
        tests++; if (pdata !== m_q[0].d || pid !== m_q[0].id) begin fails++; $display("FAIL rand_head c%0d: got %h/%0d want %h/%0d", c, pdata, pid, m_q[0].d, m_q[0].id); end
      end
      for (int k = 0; k < N; k++) begin
        if (dprev[k]) req[k] = 1'b0;
        else if (!req[k] && $urandom_range(0, 2) == 0) begin
          req[k] = 1'b1;
          dat[k] = $urandom;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_full();
    test_wrap();
    test_reset_mid();
    test_empty_ready();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
